// File: rtl/mem_access_scheduler_pkg.sv
// Shared types for the memory access scheduler.
//   memory_source_e : identifies who issued a memory access (tag queue payload)
//   REQ_*           : bit positions of each requester in req/gnt vectors
package mem_access_scheduler_pkg;

  typedef enum logic [1:0] {
    IFMAP_BUFFER  = 2'd0,
    WEIGHT_BUFFER = 2'd1,
    COMPRESSOR    = 2'd2,
    NONE          = 2'd3
  } memory_source_e;

  localparam int NUM_REQ    = 3;
  localparam int REQ_IFMAP  = 0;
  localparam int REQ_WEIGHT = 1;
  localparam int REQ_COMP   = 2;

endpackage

// File: rtl/mem_tag_queue.sv
// In-order tag FIFO remembering the issuer of every in-flight read.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            empties the queue (layer start)
//   push, push_src   enqueue the source of a newly issued read
//   pop              dequeue the head on a read return
//   head_src         source at the head of the queue
//   count            number of entries held
//   empty, full      occupancy flags
// A push and a pop in the same cycle are accepted even when full.
module mem_tag_queue
  import mem_access_scheduler_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  memory_source_e           push_src,
  input  logic                     pop,
  output memory_source_e           head_src,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  memory_source_e     store [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign push_ok  = push & (~full | pop);
  assign pop_ok   = pop & ~empty;
  assign head_src = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_src;
  end

endmodule

// File: rtl/mem_access_scheduler.sv
// Shares one external memory port between the decompressor (ifmap reads),
// the weight buffer (reads) and the compressor (writes).
// Round-robin grant, one access per cycle, per-requester address counters,
// in-order tracking of read returns routed back to their issuer.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start                            reload bases, flush tracking, clear error
//   ifmap_base/weight_base/comp_base base addresses sampled on start
//   req[2:0], comp_wdata             requests ([0] ifmap, [1] weight, [2] comp)
//   gnt[2:0]                         one-hot grant in the issue cycle
//   mem_addr, mem_read_valid,
//   mem_write_valid, mem_write_data  memory issue port
//   mem_data, mem_valid              memory read return
//   rd_data, rd_valid[1:0]           return routed to ifmap [0] / weight [1]
//   outstanding                      reads in flight
//   err_unexp_rsp                    sticky: return seen with nothing in flight
module mem_access_scheduler
  import mem_access_scheduler_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            ifmap_base,
  input  logic [ADDR_W-1:0]            weight_base,
  input  logic [ADDR_W-1:0]            comp_base,
  input  logic [2:0]                   req,
  input  logic [DATA_W-1:0]            comp_wdata,
  output logic [2:0]                   gnt,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_read_valid,
  output logic                         mem_write_valid,
  output logic [DATA_W-1:0]            mem_write_data,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         mem_valid,
  output logic [DATA_W-1:0]            rd_data,
  output logic [1:0]                   rd_valid,
  output logic [$clog2(MAX_OUTST):0]   outstanding,
  output logic                         err_unexp_rsp
);

  logic [ADDR_W-1:0]  addr_cnt [NUM_REQ];
  logic [1:0]         rr_ptr;
  logic [2:0]         elig;
  logic [1:0]         cand0;
  logic [1:0]         cand1;
  logic [1:0]         cand2;
  logic [1:0]         sel;
  logic               any_elig;
  logic               issue;
  logic               pop;
  logic               q_full;
  logic               q_empty;
  memory_source_e     q_head;
  memory_source_e     push_src;

  function automatic logic [1:0] next_req(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Reads are held back once the tag queue is full; writes never need a tag.
  assign elig = {req[REQ_COMP], req[REQ_WEIGHT] & ~q_full, req[REQ_IFMAP] & ~q_full};

  always_comb begin
    cand0    = rr_ptr;
    cand1    = next_req(cand0);
    cand2    = next_req(cand1);
    sel      = cand0;
    any_elig = 1'b1;
    if (elig[cand0])      sel = cand0;
    else if (elig[cand1]) sel = cand1;
    else if (elig[cand2]) sel = cand2;
    else                  any_elig = 1'b0;
  end

  assign issue           = any_elig & ~rst & ~start;
  assign gnt             = issue ? (3'b001 << sel) : 3'b000;
  assign mem_addr        = issue ? addr_cnt[sel] : '0;
  assign mem_read_valid  = gnt[REQ_IFMAP] | gnt[REQ_WEIGHT];
  assign mem_write_valid = gnt[REQ_COMP];
  assign mem_write_data  = comp_wdata;
  assign push_src        = gnt[REQ_IFMAP] ? IFMAP_BUFFER : WEIGHT_BUFFER;

  // Returns are routed in the same cycle they arrive, using the queue head.
  assign pop         = mem_valid & ~q_empty & ~rst & ~start;
  assign rd_data     = mem_data;
  assign rd_valid[0] = pop & (q_head == IFMAP_BUFFER);
  assign rd_valid[1] = pop & (q_head == WEIGHT_BUFFER);

  mem_tag_queue #(
    .DEPTH (MAX_OUTST)
  ) u_tag_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (start),
    .push     (mem_read_valid),
    .push_src (push_src),
    .pop      (pop),
    .head_src (q_head),
    .count    (outstanding),
    .empty    (q_empty),
    .full     (q_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= 2'd0;
      err_unexp_rsp <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) addr_cnt[i] <= '0;
    end else if (start) begin
      rr_ptr               <= 2'd0;
      err_unexp_rsp        <= 1'b0;
      addr_cnt[REQ_IFMAP]  <= ifmap_base;
      addr_cnt[REQ_WEIGHT] <= weight_base;
      addr_cnt[REQ_COMP]   <= comp_base;
    end else begin
      if (issue) begin
        rr_ptr        <= next_req(sel);
        addr_cnt[sel] <= addr_cnt[sel] + 1'b1;
      end
      if (mem_valid && q_empty) err_unexp_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Randomized and directed bench for mem_access_scheduler with a queue-based
// reference model of arbitration, address counters and read-return routing.
module tb_mem_access_scheduler;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_OUTST = 16;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic [ADDR_W-1:0]           ifmap_base;
  logic [ADDR_W-1:0]           weight_base;
  logic [ADDR_W-1:0]           comp_base;
  logic [2:0]                  req;
  logic [DATA_W-1:0]           comp_wdata;
  logic [2:0]                  gnt;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_read_valid;
  logic                        mem_write_valid;
  logic [DATA_W-1:0]           mem_write_data;
  logic [DATA_W-1:0]           mem_data;
  logic                        mem_valid;
  logic [DATA_W-1:0]           rd_data;
  logic [1:0]                  rd_valid;
  logic [$clog2(MAX_OUTST):0]  outstanding;
  logic                        err_unexp_rsp;

  mem_access_scheduler #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .ifmap_base      (ifmap_base),
    .weight_base     (weight_base),
    .comp_base       (comp_base),
    .req             (req),
    .comp_wdata      (comp_wdata),
    .gnt             (gnt),
    .mem_addr        (mem_addr),
    .mem_read_valid  (mem_read_valid),
    .mem_write_valid (mem_write_valid),
    .mem_write_data  (mem_write_data),
    .mem_data        (mem_data),
    .mem_valid       (mem_valid),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .outstanding     (outstanding),
    .err_unexp_rsp   (err_unexp_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int                m_ptr;
  logic [ADDR_W-1:0] m_cnt [3];
  int                m_q [$];
  bit                m_err;

  // DUT outputs captured in the most recent step
  logic [2:0]        cap_gnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [1:0]        cap_rdv;
  int                cap_out;
  logic              cap_err;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock cycle: inputs already driven by the caller.
  task automatic step();
    int         sel;
    int         j;
    logic [2:0] e_gnt;
    logic [ADDR_W-1:0] e_addr;
    logic [1:0] e_rdv;
    comp_wdata = $urandom;
    mem_data   = $urandom;
    #1;
    sel    = -1;
    e_gnt  = '0;
    e_addr = '0;
    e_rdv  = '0;
    if (!rst && !start) begin
      for (int k = 0; k < 3; k++) begin
        j = (m_ptr + k) % 3;
        if (sel < 0 && req[j] && (j == 2 || m_q.size() < MAX_OUTST)) sel = j;
      end
      if (sel >= 0) begin
        e_gnt[sel] = 1'b1;
        e_addr     = m_cnt[sel];
      end
      if (mem_valid && m_q.size() > 0) e_rdv[m_q[0]] = 1'b1;
    end
    check("gnt", 64'(gnt), 64'(e_gnt));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_read_valid", 64'(mem_read_valid), 64'(e_gnt[0] | e_gnt[1]));
    check("mem_write_valid", 64'(mem_write_valid), 64'(e_gnt[2]));
    check("mem_write_data", 64'(mem_write_data), 64'(comp_wdata));
    check("rd_data", 64'(rd_data), 64'(mem_data));
    check("rd_valid", 64'(rd_valid), 64'(e_rdv));
    check("outstanding", 64'(outstanding), 64'(m_q.size()));
    check("err_unexp_rsp", 64'(err_unexp_rsp), 64'(m_err));
    cap_gnt  = gnt;
    cap_addr = mem_addr;
    cap_rdv  = rd_valid;
    cap_out  = int'(outstanding);
    cap_err  = err_unexp_rsp;
    if (rst) begin
      m_ptr = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = '0;
      m_q.delete();
      m_err = 1'b0;
    end else if (start) begin
      m_ptr    = 0;
      m_cnt[0] = ifmap_base;
      m_cnt[1] = weight_base;
      m_cnt[2] = comp_base;
      m_q.delete();
      m_err = 1'b0;
    end else begin
      if (mem_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (sel >= 0) begin
        m_cnt[sel] = m_cnt[sel] + 1'b1;
        m_ptr      = (sel + 1) % 3;
        if (sel < 2) m_q.push_back(sel);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic mv);
    req       = r;
    mem_valid = mv;
    step();
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] wb,
                          input logic [ADDR_W-1:0] cb);
    ifmap_base  = ib;
    weight_base = wb;
    comp_base   = cb;
    start       = 1'b1;
    drive(3'b000, 1'b0);
    start       = 1'b0;
  endtask

  logic [2:0]        t1_gnt  [6];
  logic [ADDR_W-1:0] t1_addr [6];
  int                grants;

  initial begin
    t1_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    t1_addr = '{16'h100, 16'h200, 16'h300, 16'h101, 16'h201, 16'h301};
    rst = 1'b1; start = 1'b0; req = '0; mem_valid = 1'b0;
    ifmap_base = '0; weight_base = '0; comp_base = '0;
    comp_wdata = '0; mem_data = '0;
    m_ptr = 0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = '0;
    step();
    step();
    rst = 1'b0;
    drive(3'b000, 1'b0);
    check("reset_outstanding", 64'(cap_out), 64'd0);
    check("reset_gnt", 64'(cap_gnt), 64'd0);

    // Round robin across all three requesters
    do_start(16'h100, 16'h200, 16'h300);
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 1'b0);
      check("t1_gnt", 64'(cap_gnt), 64'(t1_gnt[i]));
      check("t1_addr", 64'(cap_addr), 64'(t1_addr[i]));
    end

    // Read throttling at MAX_OUTST
    do_start(16'h1000, 16'h2000, 16'h3000);
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      drive(3'b010, 1'b0);
      if (cap_gnt == 3'b010) grants++;
    end
    check("t2_grants", 64'(grants), 64'd16);
    check("t2_full_gnt", 64'(cap_gnt), 64'd0);
    check("t2_full_out", 64'(cap_out), 64'd16);
    drive(3'b010, 1'b1);
    check("t2_rdv", 64'(cap_rdv), 64'b10);
    check("t2_no_gnt_on_pop", 64'(cap_gnt), 64'd0);
    drive(3'b010, 1'b0);
    check("t2_resume_gnt", 64'(cap_gnt), 64'b010);
    check("t2_resume_out", 64'(cap_out), 64'd15);

    // Push and pop together around full
    drive(3'b010, 1'b1);
    check("t3_full_pop_out", 64'(cap_out), 64'd16);
    drive(3'b010, 1'b1);
    check("t3_pushpop_gnt", 64'(cap_gnt), 64'b010);
    check("t3_pushpop_rdv", 64'(cap_rdv), 64'b10);
    drive(3'b000, 1'b0);
    check("t3_pushpop_out", 64'(cap_out), 64'd15);

    // In-order routing of interleaved reads
    do_start(16'h10, 16'h20, 16'h30);
    drive(3'b001, 1'b0);
    check("t3_d0", 64'(cap_gnt), 64'b001);
    drive(3'b010, 1'b0);
    check("t3_w", 64'(cap_gnt), 64'b010);
    drive(3'b001, 1'b0);
    check("t3_d1", 64'(cap_gnt), 64'b001);
    check("t3_d1_addr", 64'(cap_addr), 64'h11);
    drive(3'b000, 1'b1);
    check("t3_rdv0", 64'(cap_rdv), 64'b01);
    drive(3'b000, 1'b1);
    check("t3_rdv1", 64'(cap_rdv), 64'b10);
    drive(3'b000, 1'b1);
    check("t3_rdv2", 64'(cap_rdv), 64'b01);

    // Unexpected return is dropped and sticky until start
    drive(3'b000, 1'b1);
    check("t4_no_rdv", 64'(cap_rdv), 64'd0);
    drive(3'b000, 1'b0);
    check("t4_err_set", 64'(cap_err), 64'd1);
    drive(3'b000, 1'b0);
    check("t4_err_sticky", 64'(cap_err), 64'd1);
    do_start(16'h40, 16'h50, 16'h60);
    drive(3'b100, 1'b0);
    check("t4_err_clear", 64'(cap_err), 64'd0);
    check("t4_comp_addr", 64'(cap_addr), 64'h60);

    // Address counter wrap
    do_start(16'h0, 16'hFFFF, 16'h0);
    drive(3'b010, 1'b0);
    check("t5_addr_top", 64'(cap_addr), 64'hFFFF);
    drive(3'b010, 1'b0);
    check("t5_addr_wrap", 64'(cap_addr), 64'h0);

    // Reset with reads in flight
    do_start(16'h500, 16'h600, 16'h700);
    for (int i = 0; i < 5; i++) drive(3'b001, 1'b0);
    rst = 1'b1;
    drive(3'b000, 1'b0);
    check("t6_out_before_rst", 64'(cap_out), 64'd5);
    rst = 1'b0;
    drive(3'b000, 1'b0);
    check("t6_out_after_rst", 64'(cap_out), 64'd0);
    check("t6_gnt_after_rst", 64'(cap_gnt), 64'd0);
    drive(3'b111, 1'b0);
    check("t6_ptr_reset", 64'(cap_gnt), 64'b001);
    check("t6_addr_reset", 64'(cap_addr), 64'h0);

    // Randomized traffic against the model
    do_start(16'($urandom), 16'($urandom), 16'($urandom));
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = !rst && ($urandom_range(0, 79) == 0);
      if (start) begin
        ifmap_base  = 16'($urandom);
        weight_base = 16'($urandom);
        comp_base   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      end
      req       = 3'($urandom);
      mem_valid = !rst && !start &&
                  ($urandom_range(0, 99) < ((i < 1500) ? 30 : 65));
      step();
    end
    rst = 1'b0; start = 1'b0; req = '0; mem_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
